// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit CPU pipeline: datapath widths and the
// special register indices used by decode, the register file and bypassing.
package cpu_pkg;

    localparam int DATA_W = 16;  // operand/result width
    localparam int IDX_W  = 4;   // register index width
    localparam int CTRL_W = 12;  // opaque decoded-control bundle width

    // Index 0 doubles as "no destination"; the register file drops writes to it.
    localparam logic [3:0] REG_NONE = 4'd0;
    localparam logic [3:0] REG_IH   = 4'd8;
    localparam logic [3:0] REG_SP   = 4'd9;
    localparam logic [3:0] REG_RA   = 4'd10;

endpackage

// File: rtl/operand_bypass_mux.sv
// Priority operand select for one source port: EX result first, then MEM
// result, then the register file read. A destination of REG_NONE never matches,
// so an instruction without a write (or a bubble) can never forward.
module operand_bypass_mux #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int IDX_W  = cpu_pkg::IDX_W
) (
    input  logic [IDX_W-1:0]  src,
    input  logic [IDX_W-1:0]  exDst,
    input  logic [DATA_W-1:0] exData,
    input  logic [IDX_W-1:0]  memDst,
    input  logic [DATA_W-1:0] memData,
    input  logic [DATA_W-1:0] rfData,
    output logic [DATA_W-1:0] operand
);
    import cpu_pkg::*;

    logic exHit;
    logic memHit;

    assign exHit  = (src == exDst)  && (exDst  != IDX_W'(REG_NONE));
    assign memHit = (src == memDst) && (memDst != IDX_W'(REG_NONE));

    // Youngest producer wins: EX over MEM over the architectural value.
    always_comb begin
        operand = rfData;
        if (exHit) begin
            operand = exData;
        end else if (memHit) begin
            operand = memData;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// ID->EX stage: drives the register file read ports, resolves operands through
// the EX/MEM bypass, detects load-use hazards and holds the ID/EX latch.
// WB writes land in the register file on the falling edge, so WB is not bypassed.
//
// Flow control: decode presents an instruction with id_valid. stall (comb) asks
// decode to hold PC and the IF/ID latch; the held instruction is re-presented
// and accepted on the first edge where stall is low. of_valid marks the ID/EX
// latch as holding a live instruction; a bubble has of_valid, of_dst and
// of_is_load all 0.
module operand_fetch #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int IDX_W  = cpu_pkg::IDX_W,
    parameter int CTRL_W = cpu_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [IDX_W-1:0]  id_src_s,
    input  logic [IDX_W-1:0]  id_src_m,
    input  logic              id_use_s,
    input  logic              id_use_m,
    input  logic              id_use_t,
    input  logic [IDX_W-1:0]  id_dst,
    input  logic              id_is_load,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [IDX_W-1:0]  rf_index_s,
    output logic [IDX_W-1:0]  rf_index_m,
    input  logic [DATA_W-1:0] rf_data_s,
    input  logic [DATA_W-1:0] rf_data_m,
    input  logic              rf_t,
    input  logic [IDX_W-1:0]  fw_ex_dst,
    input  logic [DATA_W-1:0] fw_ex_data,
    input  logic              fw_ex_load,
    input  logic              fw_ex_t_we,
    input  logic              fw_ex_t,
    input  logic [IDX_W-1:0]  fw_mem_dst,
    input  logic [DATA_W-1:0] fw_mem_data,
    input  logic              flush,
    output logic              stall,
    output logic              of_valid,
    output logic [DATA_W-1:0] of_op_s,
    output logic [DATA_W-1:0] of_op_m,
    output logic              of_t,
    output logic [DATA_W-1:0] of_imm,
    output logic [CTRL_W-1:0] of_ctrl,
    output logic [IDX_W-1:0]  of_dst,
    output logic              of_is_load,
    output logic [15:0]       stall_count
);
    import cpu_pkg::*;

    logic [DATA_W-1:0] opS;
    logic [DATA_W-1:0] opM;
    logic              tResolved;
    logic              exLoadLive;
    logic              hazard;

    // Register file reads are addressed straight from decode (0-cycle latency).
    assign rf_index_s = id_src_s;
    assign rf_index_m = id_src_m;

    operand_bypass_mux #(.DATA_W(DATA_W), .IDX_W(IDX_W)) uBypassS (
        .src     (id_src_s),
        .exDst   (fw_ex_dst),
        .exData  (fw_ex_data),
        .memDst  (fw_mem_dst),
        .memData (fw_mem_data),
        .rfData  (rf_data_s),
        .operand (opS)
    );

    operand_bypass_mux #(.DATA_W(DATA_W), .IDX_W(IDX_W)) uBypassM (
        .src     (id_src_m),
        .exDst   (fw_ex_dst),
        .exData  (fw_ex_data),
        .memDst  (fw_mem_dst),
        .memData (fw_mem_data),
        .rfData  (rf_data_m),
        .operand (opM)
    );

    // T is produced in EX only, so a single-level bypass covers it.
    assign tResolved = fw_ex_t_we ? fw_ex_t : rf_t;

    // Load data is not ready until MEM; a consumer directly behind a load waits one cycle.
    assign exLoadLive = fw_ex_load && (fw_ex_dst != IDX_W'(REG_NONE));
    assign hazard = id_valid && exLoadLive &&
                    ((id_use_s && (id_src_s == fw_ex_dst)) ||
                     (id_use_m && (id_src_m == fw_ex_dst)));

    // A flush kills the waiting instruction, so there is nothing to hold; reset forces 0.
    assign stall = rst && hazard && !flush;

    // ID/EX latch: flush clears, hazard inserts a bubble, otherwise capture decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            of_valid   <= 1'b0;
            of_op_s    <= '0;
            of_op_m    <= '0;
            of_t       <= 1'b0;
            of_imm     <= '0;
            of_ctrl    <= '0;
            of_dst     <= '0;
            of_is_load <= 1'b0;
        end else if (flush) begin
            of_valid   <= 1'b0;
            of_op_s    <= '0;
            of_op_m    <= '0;
            of_t       <= 1'b0;
            of_imm     <= '0;
            of_ctrl    <= '0;
            of_dst     <= '0;
            of_is_load <= 1'b0;
        end else if (hazard) begin
            of_valid   <= 1'b0;
            of_dst     <= '0;
            of_is_load <= 1'b0;
        end else begin
            of_valid   <= id_valid;
            of_op_s    <= opS;
            of_op_m    <= opM;
            of_t       <= id_use_t ? tResolved : rf_t;
            of_imm     <= id_imm;
            of_ctrl    <= id_ctrl;
            // An empty slot must never look like a producer to the bypass network.
            of_dst     <= id_valid ? id_dst : IDX_W'(REG_NONE);
            of_is_load <= id_valid && id_is_load;
        end
    end

    // Saturating count of cycles lost to load-use stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= 16'd0;
        end else if (stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: bypass priority, T resolution, load-use
// bubble, flush override, bubble suppression and asynchronous reset.
module tb_operand_fetch;
    import cpu_pkg::*;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic [IDX_W-1:0]  id_src_s;
    logic [IDX_W-1:0]  id_src_m;
    logic              id_use_s;
    logic              id_use_m;
    logic              id_use_t;
    logic [IDX_W-1:0]  id_dst;
    logic              id_is_load;
    logic [DATA_W-1:0] id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic [IDX_W-1:0]  rf_index_s;
    logic [IDX_W-1:0]  rf_index_m;
    logic [DATA_W-1:0] rf_data_s;
    logic [DATA_W-1:0] rf_data_m;
    logic              rf_t;
    logic [IDX_W-1:0]  fw_ex_dst;
    logic [DATA_W-1:0] fw_ex_data;
    logic              fw_ex_load;
    logic              fw_ex_t_we;
    logic              fw_ex_t;
    logic [IDX_W-1:0]  fw_mem_dst;
    logic [DATA_W-1:0] fw_mem_data;
    logic              flush;
    logic              stall;
    logic              of_valid;
    logic [DATA_W-1:0] of_op_s;
    logic [DATA_W-1:0] of_op_m;
    logic              of_t;
    logic [DATA_W-1:0] of_imm;
    logic [CTRL_W-1:0] of_ctrl;
    logic [IDX_W-1:0]  of_dst;
    logic              of_is_load;
    logic [15:0]       stall_count;

    int testsRun = 0;
    int testsFailed = 0;
    logic [DATA_W-1:0] expQ[$];

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_src_s(id_src_s), .id_src_m(id_src_m),
        .id_use_s(id_use_s), .id_use_m(id_use_m), .id_use_t(id_use_t),
        .id_dst(id_dst), .id_is_load(id_is_load), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .rf_index_s(rf_index_s), .rf_index_m(rf_index_m),
        .rf_data_s(rf_data_s), .rf_data_m(rf_data_m), .rf_t(rf_t),
        .fw_ex_dst(fw_ex_dst), .fw_ex_data(fw_ex_data), .fw_ex_load(fw_ex_load),
        .fw_ex_t_we(fw_ex_t_we), .fw_ex_t(fw_ex_t),
        .fw_mem_dst(fw_mem_dst), .fw_mem_data(fw_mem_data),
        .flush(flush), .stall(stall),
        .of_valid(of_valid), .of_op_s(of_op_s), .of_op_m(of_op_m), .of_t(of_t),
        .of_imm(of_imm), .of_ctrl(of_ctrl), .of_dst(of_dst), .of_is_load(of_is_load),
        .stall_count(stall_count)
    );

    // Clock: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog: the directed sequence is short; anything this long is a hang.
    initial begin
        #20000;
        $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pops the scoreboard's expected S operand and compares it with the latch.
    task automatic checkOpS(input string tag);
        logic [DATA_W-1:0] e;
        if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            e = expQ.pop_front();
            check(tag, 32'(of_op_s), 32'(e));
        end
    endtask

    // Advance one clock and settle past the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        id_valid = 0; id_src_s = '0; id_src_m = '0; id_use_s = 0; id_use_m = 0;
        id_use_t = 0; id_dst = '0; id_is_load = 0; id_imm = '0; id_ctrl = '0;
        rf_data_s = '0; rf_data_m = '0; rf_t = 0;
        fw_ex_dst = '0; fw_ex_data = '0; fw_ex_load = 0; fw_ex_t_we = 0; fw_ex_t = 0;
        fw_mem_dst = '0; fw_mem_data = '0; flush = 0;
    endtask

    // Present an instruction reading S (and M) from decode.
    task automatic driveIssue(input logic [IDX_W-1:0] srcS, input logic [IDX_W-1:0] srcM,
                              input logic [IDX_W-1:0] dst, input logic isLoad,
                              input logic [DATA_W-1:0] imm, input logic [CTRL_W-1:0] ctrl);
        id_valid = 1; id_src_s = srcS; id_src_m = srcM; id_use_s = 1; id_use_m = 1;
        id_dst = dst; id_is_load = isLoad; id_imm = imm; id_ctrl = ctrl;
    endtask

    initial begin
        rst = 1'b0;
        idleInputs();
        // A would-be hazard during reset must not raise stall.
        driveIssue(4'd3, 4'd0, 4'd1, 0, 16'h0, 12'h0);
        fw_ex_dst = 4'd3; fw_ex_load = 1;
        step();
        step();
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_of_valid", 32'(of_valid), 32'd0);
        check("reset_stall_count", 32'(stall_count), 32'd0);
        idleInputs();
        rst = 1'b1;
        step();

        // EX bypass on S: ADDU R1 in EX produced 0x0042; stale rf value ignored.
        driveIssue(4'd1, 4'd6, 4'd5, 0, 16'h1234, 12'hABC);
        rf_data_s = 16'h9999; rf_data_m = 16'h0606;
        fw_ex_dst = 4'd1; fw_ex_data = 16'h0042;
        #1;
        check("rf_index_s", 32'(rf_index_s), 32'd1);
        check("rf_index_m", 32'(rf_index_m), 32'd6);
        check("no_stall_alu", 32'(stall), 32'd0);
        expQ.push_back(16'h0042);
        step();
        checkOpS("ex_bypass_s");
        check("ex_bypass_m_rf", 32'(of_op_m), 32'h0606);
        check("latch_valid", 32'(of_valid), 32'd1);
        check("latch_imm", 32'(of_imm), 32'h1234);
        check("latch_ctrl", 32'(of_ctrl), 32'hABC);
        check("latch_dst", 32'(of_dst), 32'd5);

        // EX beats MEM for the same register; T comes from EX when it writes T.
        idleInputs();
        driveIssue(4'd7, 4'd2, 4'd4, 0, 16'h0, 12'h0);
        id_use_t = 1; rf_t = 0; fw_ex_t_we = 1; fw_ex_t = 1;
        rf_data_s = 16'h7777; rf_data_m = 16'h3333;
        fw_ex_dst = 4'd2; fw_ex_data = 16'h1111;
        fw_mem_dst = 4'd2; fw_mem_data = 16'h2222;
        expQ.push_back(16'h7777);
        step();
        check("ex_over_mem_m", 32'(of_op_m), 32'h1111);
        checkOpS("rf_s_no_match");
        check("t_from_ex", 32'(of_t), 32'd1);

        // MEM-only match; T from register file when EX does not write T.
        fw_ex_dst = 4'd0; fw_ex_t_we = 0; rf_t = 1; fw_ex_t = 0;
        step();
        check("mem_bypass_m", 32'(of_op_m), 32'h2222);
        check("t_from_rf", 32'(of_t), 32'd1);

        // Load-use on S: LW R3 in EX, consumer reads R3 -> one bubble.
        idleInputs();
        driveIssue(4'd3, 4'd5, 4'd6, 0, 16'h0, 12'h0);
        fw_ex_dst = 4'd3; fw_ex_load = 1; fw_ex_data = 16'hDEAD;
        #1;
        check("loaduse_stall", 32'(stall), 32'd1);
        step();
        check("bubble_valid", 32'(of_valid), 32'd0);
        check("bubble_dst", 32'(of_dst), 32'd0);
        check("bubble_is_load", 32'(of_is_load), 32'd0);
        check("stall_count_1", 32'(stall_count), 32'd1);
        // Load now in MEM: served from fw_mem_data, no further stall.
        fw_ex_dst = 4'd0; fw_ex_load = 0;
        fw_mem_dst = 4'd3; fw_mem_data = 16'hBEEF; rf_data_s = 16'h0BAD;
        #1;
        check("after_load_no_stall", 32'(stall), 32'd0);
        expQ.push_back(16'hBEEF);
        step();
        checkOpS("load_data_via_mem");
        check("after_load_valid", 32'(of_valid), 32'd1);
        check("stall_count_held", 32'(stall_count), 32'd1);

        // Same register in EX load but the operand is not used: no hazard.
        idleInputs();
        driveIssue(4'd3, 4'd0, 4'd2, 1, 16'h0, 12'h0);
        id_use_s = 0; id_use_m = 0;
        fw_ex_dst = 4'd3; fw_ex_load = 1;
        #1;
        check("unused_src_no_stall", 32'(stall), 32'd0);
        step();
        check("load_flag_latched", 32'(of_is_load), 32'd1);

        // Hazard with flush: no stall, slot killed, counter untouched.
        idleInputs();
        driveIssue(4'd4, 4'd4, 4'd1, 0, 16'h5555, 12'h0);
        fw_ex_dst = 4'd4; fw_ex_load = 1; flush = 1;
        #1;
        check("flush_no_stall", 32'(stall), 32'd0);
        step();
        check("flush_valid", 32'(of_valid), 32'd0);
        check("flush_stall_count", 32'(stall_count), 32'd1);

        // R0 never bypasses, even if EX and MEM report dst 0.
        idleInputs();
        driveIssue(4'd0, 4'd0, 4'd3, 0, 16'h0, 12'h0);
        fw_ex_dst = 4'd0; fw_ex_data = 16'hFFFF;
        fw_mem_dst = 4'd0; fw_mem_data = 16'hEEEE;
        rf_data_s = 16'h5A5A; rf_data_m = 16'hA5A5;
        expQ.push_back(16'h5A5A);
        step();
        checkOpS("r0_no_bypass_s");
        check("r0_no_bypass_m", 32'(of_op_m), 32'hA5A5);

        // Empty slot latches no destination and no load.
        idleInputs();
        id_dst = 4'd7; id_is_load = 1;
        step();
        check("idle_valid", 32'(of_valid), 32'd0);
        check("idle_dst", 32'(of_dst), 32'd0);
        check("idle_is_load", 32'(of_is_load), 32'd0);

        // Asynchronous reset mid-stream with a live instruction in the latch.
        idleInputs();
        driveIssue(4'd1, 4'd2, 4'd5, 1, 16'h4321, 12'h123);
        rf_data_s = 16'h1357; rf_t = 1; id_use_t = 1;
        step();
        check("pre_reset_valid", 32'(of_valid), 32'd1);
        fw_ex_dst = 4'd1; fw_ex_load = 1;
        #2;
        rst = 1'b0;
        #1;
        check("async_valid", 32'(of_valid), 32'd0);
        check("async_op_s", 32'(of_op_s), 32'd0);
        check("async_imm", 32'(of_imm), 32'd0);
        check("async_ctrl", 32'(of_ctrl), 32'd0);
        check("async_dst", 32'(of_dst), 32'd0);
        check("async_is_load", 32'(of_is_load), 32'd0);
        check("async_t", 32'(of_t), 32'd0);
        check("async_stall_count", 32'(stall_count), 32'd0);
        check("async_stall", 32'(stall), 32'd0);
        idleInputs();
        step();
        rst = 1'b1;
        step();

        check("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
